ctrl_router: RTL and testbench
==============================

# ctrl_router

Parametrised control router that fans one shared front-panel control bus out to `NUM_CH` independent subsystem channels. It sits between the button/switch debouncers and the per-subsystem control inputs. Each channel has a shadow (staged) data register and a committed data register; staged data reaches a subsystem only on an edge-detected commit. Mode bits pass through live to the active channel. The block reports per-channel dirty flags, one-cycle commit pulses and a registered status word for the display.

## Interface
Parameters:
- `NUM_CH`, 3: number of channels; legal range 2..16, power of two not required.
- `DATA_W`, 8: width of staged/committed data per channel.
- `MODE_W`, 2: width of live mode bits per channel.
- `CH_W`, `$clog2(NUM_CH)`: derived channel-index width; not overridden.

Ports:
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `select_valid`  in  1  level; requests a change of active channel this cycle.
- `select_ch`  in  CH_W  requested channel index.
- `data_in`  in  DATA_W  data staged into the active channel's shadow.
- `mode_in`  in  MODE_W  live mode bits for the active channel.
- `enter`  in  1  level, debounced; a rising edge commits the active channel.
- `commit_all`  in  1  level, debounced; a rising edge commits every dirty channel.
- `ch_data`  out  NUM_CH*DATA_W  committed data; channel c at `[c*DATA_W +: DATA_W]`.
- `ch_mode`  out  NUM_CH*MODE_W  mode bits; channel c at `[c*MODE_W +: MODE_W]`.
- `active_ch`  out  CH_W  currently active channel.
- `dirty`  out  NUM_CH  bit c high when shadow[c] != committed[c].
- `commit_pulse`  out  NUM_CH  one-cycle pulse per channel committed.
- `status`  out  CH_W+MODE_W+DATA_W  registered `{active_ch, mode[active], data[active]}`.

## Operation
- Reset: all shadow, data and mode registers, `active_ch`, `commit_pulse` and `status` go to 0. The edge-detect registers for `enter` and `commit_all` go to 1, so a button held through reset release does not fire.
- The edge registers sample `enter` and `commit_all` every non-reset cycle. Rise = input & ~registered copy.
- Priority per cycle is select, then commit, then stage.
- Select cycle (`select_valid` high and `select_ch < NUM_CH`):
  - `active_ch <= select_ch`.
  - No staging, mode update or commit happens. Any edge that occurs in this cycle is discarded.
- Out-of-range select (`select_ch >= NUM_CH`): ignored entirely. The cycle is processed as if `select_valid` were low.
- Normal cycle (no valid select):
  - `shadow[active] <= data_in`.
  - `mode[active] <= mode_in`.
  - Other channels hold their values.
- Commit, in a normal cycle:
  - On a `commit_all` rise, `data[c] <= shadow[c]` for every c with `dirty[c]`.
  - Otherwise, on an `enter` rise with `dirty[active]`, `data[active] <= shadow[active]`.
  - The committed value is the shadow value before this cycle's staging write.
  - Coincident `enter` and `commit_all` rises behave as `commit_all` alone.
  - A commit of a clean channel does nothing and produces no pulse.
- `commit_pulse[c]` is registered. It is high for exactly one cycle, the cycle after the commit, for each channel committed. It is 0 otherwise.
- `dirty` is combinational from the shadow and data registers only (no input paths).
- `status` updates every non-reset cycle from the current register values.

## Timing
- Staging: `data_in` at cycle k appears in `shadow[active]` at k+1.
- Commit: for an `enter` rise at cycle k, `ch_data` is updated at k+1 with `data_in` from k-1 or earlier.
  - `data_in` must therefore be stable for at least 1 cycle before the edge.
  - `commit_pulse` is high at k+1; `status` reflects the commit at k+2.
- Mode: `mode_in` at k appears in `ch_mode` at k+1 and in `status` at k+2.
- Select: `select_valid` at k gives `active_ch` at k+1. The first staging into the new channel uses `data_in` at k+1.
- A held `enter` produces exactly one commit. The next commit needs a low cycle followed by a high cycle.
- Reset asserted mid-operation clears everything on the next edge. No commit pulse is issued for a commit in flight.

## Test plan
- **Reset and held button.** Reset with `enter=1` held, then release reset. Required: all outputs 0, no `commit_pulse`. Drop `enter` and raise it again: exactly one commit occurs.
- **Single commit.** Active ch0, `data_in=8'hA5` for 2 cycles, then an `enter` rise. Required: `dirty[0]=1` before the edge; `ch_data[7:0]=8'hA5` and `commit_pulse=3'b001` one cycle after the edge; `status` low byte `8'hA5` two cycles after the edge; `dirty[0]=0`.
- **Hold and commit_all.** Stage 8'h11 on ch1 and 8'h22 on ch2, re-selecting between them; ch0 stays clean. Then a `commit_all` rise. Required: `commit_pulse=3'b110` for one cycle; ch1=8'h11, ch2=8'h22, ch0 unchanged.
- **Select priority.** Select ch2 in the same cycle as an `enter` rise with ch0 dirty. Required: `active_ch=2`, no commit, ch0 still dirty. Select with `select_ch=3` while `NUM_CH=3`: `active_ch` is unchanged and staging continues normally.
- **Clean commit and live mode.** An `enter` rise on a clean channel: no pulse, data unchanged. `mode_in=2'b10` on ch1: `ch_mode[3:2]=2'b10` after 1 cycle, with no enter needed.
- **Reset mid-commit.** Assert reset in the cycle of an `enter` rise. Required: all zeros next cycle, `commit_pulse=0`.

Source files
------------

// File: rtl/ctrl_router_if.sv
// Front-panel control bus shared between the panel side (master) and
// ctrl_router (slave): request inputs in one direction, channel outputs back.
interface ctrl_router_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int MODE_W = 2
);
    localparam int CH_W = $clog2(NUM_CH);

    logic                          select_valid;
    logic [CH_W-1:0]               select_ch;
    logic [DATA_W-1:0]             data_in;
    logic [MODE_W-1:0]             mode_in;
    logic                          enter;
    logic                          commit_all;
    logic [NUM_CH*DATA_W-1:0]      ch_data;
    logic [NUM_CH*MODE_W-1:0]      ch_mode;
    logic [CH_W-1:0]               active_ch;
    logic [NUM_CH-1:0]             dirty;
    logic [NUM_CH-1:0]             commit_pulse;
    logic [CH_W+MODE_W+DATA_W-1:0] status;

    modport master (
        output select_valid, select_ch, data_in, mode_in, enter, commit_all,
        input  ch_data, ch_mode, active_ch, dirty, commit_pulse, status
    );

    modport slave (
        input  select_valid, select_ch, data_in, mode_in, enter, commit_all,
        output ch_data, ch_mode, active_ch, dirty, commit_pulse, status
    );
endinterface

// File: rtl/ctrl_router.sv
// Fans one front-panel control bus out to NUM_CH channels: staged shadow data,
// edge-triggered commits, live mode bits and a registered display status word.
module ctrl_router #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int MODE_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    ctrl_router_if.slave bus
);
    localparam int CH_W     = $clog2(NUM_CH);
    localparam int STATUS_W = CH_W + MODE_W + DATA_W;

    logic [DATA_W-1:0]   shadow_q [NUM_CH];
    logic [DATA_W-1:0]   data_q   [NUM_CH];
    logic [MODE_W-1:0]   mode_q   [NUM_CH];
    logic [CH_W-1:0]     active_q;
    logic                enter_q;
    logic                commit_all_q;
    logic [NUM_CH-1:0]   pulse_q;
    logic [STATUS_W-1:0] status_q;

    logic                     select_ok;
    logic                     enter_rise;
    logic                     all_rise;
    logic [NUM_CH-1:0]        dirty_w;
    logic [NUM_CH-1:0]        commit_mask;
    logic [NUM_CH*DATA_W-1:0] ch_data_w;
    logic [NUM_CH*MODE_W-1:0] ch_mode_w;

    assign select_ok  = bus.select_valid && ({1'b0, bus.select_ch} < (CH_W+1)'(NUM_CH));
    assign enter_rise = bus.enter & ~enter_q;
    assign all_rise   = bus.commit_all & ~commit_all_q;

    // A select cycle swallows any edge; commit_all overrides a coincident enter.
    always_comb begin
        dirty_w     = '0;
        commit_mask = '0;
        ch_data_w   = '0;
        ch_mode_w   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            dirty_w[c] = (shadow_q[c] != data_q[c]);
            ch_data_w[c*DATA_W +: DATA_W] = data_q[c];
            ch_mode_w[c*MODE_W +: MODE_W] = mode_q[c];
            if (!select_ok) begin
                if (all_rise)
                    commit_mask[c] = dirty_w[c];
                else if (enter_rise && (CH_W'(c) == active_q))
                    commit_mask[c] = dirty_w[c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                shadow_q[c] <= '0;
                data_q[c]   <= '0;
                mode_q[c]   <= '0;
            end
            active_q     <= '0;
            pulse_q      <= '0;
            status_q     <= '0;
            // Held buttons at reset release must not look like a fresh press.
            enter_q      <= 1'b1;
            commit_all_q <= 1'b1;
        end else begin
            enter_q      <= bus.enter;
            commit_all_q <= bus.commit_all;
            pulse_q      <= commit_mask;
            status_q     <= {active_q, mode_q[active_q], data_q[active_q]};
            if (select_ok) begin
                active_q <= bus.select_ch;
            end else begin
                shadow_q[active_q] <= bus.data_in;
                mode_q[active_q]   <= bus.mode_in;
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (commit_mask[c])
                        data_q[c] <= shadow_q[c];
                end
            end
        end
    end

    assign bus.ch_data      = ch_data_w;
    assign bus.ch_mode      = ch_mode_w;
    assign bus.active_ch    = active_q;
    assign bus.dirty        = dirty_w;
    assign bus.commit_pulse = pulse_q;
    assign bus.status       = status_q;
endmodule

// File: tb/tb_ctrl_router.sv
// Self-checking bench for ctrl_router: directed scenarios plus random traffic,
// every cycle compared against a behavioural channel model.
module tb_ctrl_router;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int MODE_W = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ctrl_router_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MODE_W(MODE_W)) bus ();

    ctrl_router #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MODE_W(MODE_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    logic [7:0]  m_sh   [NUM_CH];
    logic [7:0]  m_data [NUM_CH];
    logic [1:0]  m_mode [NUM_CH];
    int          m_act;
    logic        m_enter, m_all;
    logic [2:0]  m_pulse;
    logic [11:0] m_status;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit erise, arise;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_sh[c] = 0; m_data[c] = 0; m_mode[c] = 0;
            end
            m_act = 0; m_pulse = 0; m_status = 0; m_enter = 1; m_all = 1;
            return;
        end
        erise    = bus.enter && !m_enter;
        arise    = bus.commit_all && !m_all;
        m_status = {m_act[1:0], m_mode[m_act], m_data[m_act]};
        m_pulse  = 0;
        if (bus.select_valid && int'(bus.select_ch) < NUM_CH) begin
            m_act = int'(bus.select_ch);
        end else begin
            if (arise) begin
                for (int c = 0; c < NUM_CH; c++)
                    if (m_sh[c] != m_data[c]) begin
                        m_data[c] = m_sh[c];
                        m_pulse[c] = 1'b1;
                    end
            end else if (erise && m_sh[m_act] != m_data[m_act]) begin
                m_data[m_act]  = m_sh[m_act];
                m_pulse[m_act] = 1'b1;
            end
            m_sh[m_act]   = bus.data_in;
            m_mode[m_act] = bus.mode_in;
        end
        m_enter = bus.enter;
        m_all   = bus.commit_all;
    endtask

    task automatic compare_all();
        logic [23:0] exp_data;
        logic [5:0]  exp_mode;
        logic [2:0]  exp_dirty;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_data[c*8 +: 8] = m_data[c];
            exp_mode[c*2 +: 2] = m_mode[c];
            exp_dirty[c]       = (m_sh[c] != m_data[c]);
        end
        check_eq("ch_data", 64'(bus.ch_data), 64'(exp_data));
        check_eq("ch_mode", 64'(bus.ch_mode), 64'(exp_mode));
        check_eq("active_ch", 64'(bus.active_ch), 64'(m_act));
        check_eq("dirty", 64'(bus.dirty), 64'(exp_dirty));
        check_eq("commit_pulse", 64'(bus.commit_pulse), 64'(m_pulse));
        check_eq("status", 64'(bus.status), 64'(m_status));
    endtask

    // Inputs are held across the edge, the model advances, outputs are sampled 1ns later.
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit sv, input int sch, input logic [7:0] d,
                         input logic [1:0] m, input bit en, input bit all);
        bus.select_valid = sv;
        bus.select_ch    = 2'(sch);
        bus.data_in      = d;
        bus.mode_in      = m;
        bus.enter        = en;
        bus.commit_all   = all;
    endtask

    initial begin
        drive(0, 0, 8'h00, 2'b00, 1, 0);
        reset = 1;
        // Reset with enter held, then release while still held
        cycle(); cycle();
        check_eq("rst_data", 64'(bus.ch_data), 64'h0);
        check_eq("rst_status", 64'(bus.status), 64'h0);
        reset = 0;
        cycle(); cycle();
        check_eq("held_no_pulse", 64'(bus.commit_pulse), 64'h0);
        check_eq("held_data", 64'(bus.ch_data), 64'h0);
        drive(0, 0, 8'h3C, 2'b00, 0, 0); cycle(); cycle();
        drive(0, 0, 8'h3C, 2'b00, 1, 0); cycle();
        check_eq("rehit_pulse", 64'(bus.commit_pulse), 64'h1);
        cycle();
        check_eq("rehit_once", 64'(bus.commit_pulse), 64'h0);

        // Single commit of A5 on ch0
        drive(0, 0, 8'hA5, 2'b00, 0, 0); cycle(); cycle();
        check_eq("single_dirty", 64'(bus.dirty[0]), 64'h1);
        drive(0, 0, 8'hA5, 2'b00, 1, 0); cycle();
        check_eq("single_data", 64'(bus.ch_data[7:0]), 64'hA5);
        check_eq("single_pulse", 64'(bus.commit_pulse), 64'h1);
        cycle();
        check_eq("single_status", 64'(bus.status[7:0]), 64'hA5);
        check_eq("single_clean", 64'(bus.dirty[0]), 64'h0);

        // Stage ch1/ch2 with reselects, then commit_all
        drive(1, 1, 8'h00, 2'b00, 0, 0); cycle();
        drive(0, 0, 8'h11, 2'b00, 0, 0); cycle(); cycle();
        drive(1, 2, 8'h00, 2'b00, 0, 0); cycle();
        drive(0, 0, 8'h22, 2'b00, 0, 0); cycle(); cycle();
        drive(1, 1, 8'h00, 2'b00, 0, 0); cycle();
        drive(0, 0, 8'h11, 2'b00, 0, 0); cycle();
        drive(0, 0, 8'h11, 2'b00, 0, 1); cycle();
        check_eq("all_pulse", 64'(bus.commit_pulse), 64'h6);
        check_eq("all_data", 64'(bus.ch_data), 64'h2211A5);
        cycle();
        check_eq("all_pulse_once", 64'(bus.commit_pulse), 64'h0);

        // Select beats a coincident enter rise
        drive(1, 0, 8'h00, 2'b00, 0, 0); cycle();
        drive(0, 0, 8'h77, 2'b00, 0, 0); cycle(); cycle();
        drive(1, 2, 8'h77, 2'b00, 1, 0); cycle();
        check_eq("sel_active", 64'(bus.active_ch), 64'h2);
        check_eq("sel_no_pulse", 64'(bus.commit_pulse), 64'h0);
        check_eq("sel_ch0_dirty", 64'(bus.dirty[0]), 64'h1);
        drive(1, 3, 8'h99, 2'b00, 1, 0); cycle();
        check_eq("oor_active", 64'(bus.active_ch), 64'h2);
        check_eq("oor_staged", 64'(bus.dirty[2]), 64'h1);

        // Clean commit and live mode on ch1
        drive(1, 1, 8'h11, 2'b00, 0, 0); cycle();
        drive(0, 0, 8'h11, 2'b10, 0, 0); cycle();
        check_eq("live_mode", 64'(bus.ch_mode[3:2]), 64'h2);
        drive(0, 0, 8'h11, 2'b10, 1, 0); cycle();
        check_eq("clean_no_pulse", 64'(bus.commit_pulse), 64'h0);
        check_eq("clean_data", 64'(bus.ch_data[15:8]), 64'h11);

        // Reset in the cycle of an enter rise on dirty ch0
        drive(1, 0, 8'h77, 2'b00, 0, 0); cycle();
        drive(0, 0, 8'h77, 2'b00, 0, 0); cycle();
        drive(0, 0, 8'h77, 2'b00, 1, 0); reset = 1; cycle();
        check_eq("rstmid_data", 64'(bus.ch_data), 64'h0);
        check_eq("rstmid_pulse", 64'(bus.commit_pulse), 64'h0);
        reset = 0;

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 5) == 0), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : bus.data_in,
                  2'($urandom), ($urandom_range(0, 2) == 0) ? ~bus.enter : bus.enter,
                  ($urandom_range(0, 6) == 0) ? ~bus.commit_all : bus.commit_all);
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
